// File: rtl/tx_fir_shaper.sv
// tx_fir_shaper: transmit pulse-shaping / pre-emphasis FIR with a PRBS-7 training source.
// Each sample is accumulated over NUM_TAPS cycles by a single time-multiplexed MAC.
// The result is rounded half-up, saturated, and held until downstream takes it.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      input handshake; in_ready is combinational (IDLE && !train_en)
//   in_data                signed input symbol
//   train_en               1 = PRBS-7 +/-TRAIN_AMP source replaces in_data
//   coef_we/addr/wdata     coefficient bank write port
//   coef_err               one-cycle pulse when a write is dropped
//   out_valid/out_ready    output handshake
//   out_data               signed shaped sample, held stable while out_valid
module tx_fir_shaper #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned NUM_TAPS   = 32,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned TRAIN_AMP  = 8192
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    input  logic                          train_en,
    input  logic                          coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_WIDTH-1:0]  coef_wdata,
    output logic                          coef_err,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_WIDTH-1:0]  out_data
);

    localparam int unsigned ADDR_W = $clog2(NUM_TAPS);
    localparam int unsigned PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int unsigned FRAC_W = COEF_WIDTH - 2;
    localparam int unsigned LFSR_W = 7;

    localparam logic signed [COEF_WIDTH-1:0] COEF_ONE  = COEF_WIDTH'(1 << FRAC_W);
    localparam logic signed [ACC_WIDTH-1:0]  ROUND_C   = ACC_WIDTH'(1 << (FRAC_W - 1));
    localparam logic signed [ACC_WIDTH-1:0]  SAT_MAX   = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0]  SAT_MIN   = ~SAT_MAX;
    localparam logic signed [DATA_WIDTH-1:0] AMP_POS   = DATA_WIDTH'(TRAIN_AMP);
    localparam logic signed [DATA_WIDTH-1:0] AMP_NEG   = -AMP_POS;
    localparam logic [ADDR_W-1:0]            K_LAST    = ADDR_W'(NUM_TAPS - 1);
    localparam logic [LFSR_W-1:0]            LFSR_SEED = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                         state;
    state_t                         state_next;
    logic signed [DATA_WIDTH-1:0]   dl   [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0]   coef [NUM_TAPS];
    logic signed [ACC_WIDTH-1:0]    acc;
    logic [ADDR_W-1:0]              k;
    logic [LFSR_W-1:0]              lfsr;

    // Control decoded by the next-state process
    logic                           shift_en;
    logic                           sel_train;
    logic                           load_out;
    logic                           out_valid_next;
    logic                           coef_wr;
    logic                           coef_err_next;
    logic                           addr_ok;

    // Datapath combinational terms
    logic signed [DATA_WIDTH-1:0]   sample_c;
    logic signed [PROD_W-1:0]       prod_c;
    logic signed [ACC_WIDTH-1:0]    acc_sum_c;
    logic signed [ACC_WIDTH-1:0]    rnd_c;
    logic signed [ACC_WIDTH-1:0]    shr_c;
    logic signed [DATA_WIDTH-1:0]   sat_c;

    assign in_ready = (state == IDLE) && !train_en;

    // Address range check only exists when the address bus can exceed the tap count
    generate
        if ((1 << ADDR_W) > NUM_TAPS) begin : g_addr_chk
            assign addr_ok = (coef_addr < ADDR_W'(NUM_TAPS));
        end else begin : g_addr_full
            assign addr_ok = 1'b1;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_next     = state;
        shift_en       = 1'b0;
        sel_train      = 1'b0;
        load_out       = 1'b0;
        out_valid_next = out_valid;
        coef_wr        = 1'b0;
        coef_err_next  = 1'b0;

        unique case (state)
            IDLE: begin
                // Training does not wait for upstream; it free-runs one symbol per slot
                if (train_en) begin
                    shift_en   = 1'b1;
                    sel_train  = 1'b1;
                    state_next = MAC;
                end else if (in_valid) begin
                    shift_en   = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                if (k == K_LAST) begin
                    load_out       = 1'b1;
                    out_valid_next = 1'b1;
                    state_next     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                out_valid_next = 1'b0;
            end
        endcase

        // The MAC reads the bank every cycle, so writes are refused while it runs
        if (coef_we) begin
            if ((state == MAC) || !addr_ok) begin
                coef_err_next = 1'b1;
            end else begin
                coef_wr = 1'b1;
            end
        end
    end

    // Symbol source and MAC arithmetic
    always_comb begin
        sample_c  = sel_train ? (lfsr[LFSR_W-1] ? AMP_POS : AMP_NEG) : in_data;
        prod_c    = PROD_W'(dl[k]) * PROD_W'(coef[k]);
        acc_sum_c = acc + ACC_WIDTH'(prod_c);
        rnd_c     = acc_sum_c + ROUND_C;
        shr_c     = rnd_c >>> FRAC_W;
        if (shr_c > SAT_MAX) begin
            sat_c = DATA_WIDTH'(SAT_MAX);
        end else if (shr_c < SAT_MIN) begin
            sat_c = DATA_WIDTH'(SAT_MIN);
        end else begin
            sat_c = DATA_WIDTH'(shr_c);
        end
    end

    // Delay line, accumulator and tap counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                dl[i] <= '0;
            end
            acc <= '0;
            k   <= '0;
        end else if (shift_en) begin
            dl[0] <= sample_c;
            for (int i = 1; i < NUM_TAPS; i++) begin
                dl[i] <= dl[i-1];
            end
            acc <= '0;
            k   <= '0;
        end else if (state == MAC) begin
            acc <= acc_sum_c;
            k   <= k + ADDR_W'(1);
        end
    end

    // PRBS-7 generator, advances only when a training symbol is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (shift_en && sel_train) begin
            lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[LFSR_W-2]};
        end
    end

    // Coefficient bank; tap 0 resets to unity so the filter is a pass-through
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                coef[i] <= (i == 0) ? COEF_ONE : '0;
            end
        end else if (coef_wr) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            coef_err  <= 1'b0;
        end else begin
            out_valid <= out_valid_next;
            coef_err  <= coef_err_next;
            if (load_out) begin
                out_data <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_tx_fir_shaper.sv
// Self-checking bench for tx_fir_shaper: directed cases with literal expectations
// plus a randomized phase, all compared against a transaction-level model every cycle.
module tb_tx_fir_shaper;

    localparam int NT  = 32;
    localparam int AMP = 8192;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_data = '0;
    logic               train_en = 1'b0;
    logic               coef_we = 1'b0;
    logic [4:0]         coef_addr = '0;
    logic signed [15:0] coef_wdata = '0;
    logic               coef_err;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_data;

    int checks = 0;
    int failures = 0;

    tx_fir_shaper dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .train_en   (train_en),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_err   (coef_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int        m_coef [NT];
    int        m_hist [NT];
    logic [6:0] m_lfsr;
    bit        m_busy;
    bit        m_err;
    int        m_y;
    longint    edge_n = 0;
    longint    m_acc_edge;
    int        outlog [$];
    bit        m_idle, m_in_mac, m_hold;

    task automatic m_reset();
        for (int i = 0; i < NT; i++) begin
            m_coef[i] = (i == 0) ? 16384 : 0;
            m_hist[i] = 0;
        end
        m_lfsr = 7'h7F;
        m_busy = 0;
        m_err  = 0;
        m_y    = 0;
        m_acc_edge = 0;
    endtask

    // y = sat16(round_half_up(sum(x[n-i]*c[i]) / 2^14))
    task automatic m_accept(input int s);
        longint sum;
        for (int i = NT - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = s;
        sum = 0;
        for (int i = 0; i < NT; i++) sum += longint'(m_hist[i]) * longint'(m_coef[i]);
        sum = (sum + 8192) >>> 14;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        m_y = int'(sum);
        m_busy = 1;
        m_acc_edge = edge_n;
    endtask

    // Model advances on each clock edge; output valid from acceptance edge + NT
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset();
        end else begin
            edge_n++;
            m_idle   = !m_busy;
            m_in_mac = m_busy && (edge_n <= m_acc_edge + NT);
            m_hold   = m_busy && (edge_n > m_acc_edge + NT);
            m_err    = 0;
            if (coef_we) begin
                if (m_in_mac) m_err = 1;
                else m_coef[coef_addr] = int'(coef_wdata);
            end
            if (out_valid && out_ready) outlog.push_back(int'(out_data));
            if (m_idle) begin
                if (train_en) begin
                    m_accept(m_lfsr[6] ? AMP : -AMP);
                    m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
                end else if (in_valid) begin
                    m_accept(int'(in_data));
                end
            end else if (m_hold && out_ready) begin
                m_busy = 0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        bit ev;
        if (rst_n) begin
            ev = m_busy && (edge_n >= m_acc_edge + NT);
            chk("in_ready", in_ready, (!m_busy && !train_en));
            chk("out_valid", out_valid, ev);
            if (ev) chk("out_data", out_data, m_y);
            chk("coef_err", coef_err, m_err);
        end else begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_coef_err", coef_err, 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0;
        coef_we  = 0;
        train_en = 0;
        rst_n    = 0;
        tick();
        tick();
        rst_n    = 1;
    endtask

    task automatic wr_coef(input int addr, input int val);
        coef_we    = 1;
        coef_addr  = 5'(addr);
        coef_wdata = 16'(val);
        tick();
        coef_we    = 0;
    endtask

    task automatic accept(input int d);
        bit ok;
        ok = 0;
        in_data  = 16'(d);
        in_valid = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        #1;
        in_valid = 0;
        in_data  = 16'($urandom);
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int lat);
        bit ok;
        ok  = 0;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("valid_timeout", 0, 1);
    endtask

    task automatic wait_out(output int y);
        int n0;
        bit ok;
        n0 = outlog.size();
        ok = 0;
        y  = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (outlog.size() > n0) begin
                ok = 1;
                break;
            end
        end
        if (ok) y = outlog[outlog.size() - 1];
        else chk("output_timeout", 0, 1);
    endtask

    task automatic send(input int d, output int lat, output int y);
        accept(d);
        wait_valid(lat);
        wait_out(y);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat, y, n0;
        int train_exp [8];
        bit ok;

        // 1: reset defaults and pass-through
        tick();
        chk("reset_out_data", out_data, 0);
        rst_n = 1;
        tick();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        out_ready = 1;
        send(1000, lat, y);
        chk("t1_latency", lat, 33);
        chk("t1_passthru", y, 1000);
        send(-32768, lat, y);
        chk("t1_min", y, -32768);

        // 2: two-tap filter
        do_reset();
        wr_coef(1, -8192);
        send(1000, lat, y);
        chk("t2_first", y, 1000);
        send(2000, lat, y);
        chk("t2_second", y, 1500);

        // 3: saturation and rounding boundaries
        wr_coef(1, 0);
        wr_coef(0, 32767);
        send(30000, lat, y);
        chk("t3_sat_pos", y, 32767);
        send(-30000, lat, y);
        chk("t3_sat_neg", y, -32768);
        wr_coef(0, 8192);
        send(3, lat, y);
        chk("t3_round_pos", y, 2);
        send(-3, lat, y);
        chk("t3_round_neg", y, -1);

        // 4: backpressure
        do_reset();
        out_ready = 0;
        accept(1234);
        wait_valid(lat);
        in_valid = 1;
        in_data  = 16'(555);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_data", out_data, 1234);
            chk("t4_hold_ready", in_ready, 0);
        end
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("t4_ready_after", in_ready, 1);
        chk("t4_logged", outlog[outlog.size() - 1], 1234);
        @(posedge clk);
        #1;
        in_valid = 0;
        wait_valid(lat);
        wait_out(y);
        chk("t4_next", y, 555);

        // 5: training sequence
        do_reset();
        out_ready = 1;
        train_exp = '{AMP, AMP, AMP, AMP, AMP, AMP, AMP, -AMP};
        n0 = outlog.size();
        train_en = 1;
        in_data  = 16'(12345);
        ok = 0;
        for (int i = 0; i < 8 * 40 + 50; i++) begin
            tick();
            in_data = 16'($urandom);
            if (outlog.size() >= n0 + 8) begin
                ok = 1;
                break;
            end
        end
        train_en = 0;
        if (!ok) chk("t5_timeout", 0, 1);
        else for (int i = 0; i < 8; i++) chk("t5_train", outlog[n0 + i], train_exp[i]);
        repeat (40) tick();

        // 6: write during MAC, then reset in HOLD and in MAC
        do_reset();
        out_ready = 1;
        accept(700);
        repeat (5) tick();
        wr_coef(0, 99);
        @(negedge clk);
        chk("t6_err_pulse", coef_err, 1);
        @(negedge clk);
        chk("t6_err_clear", coef_err, 0);
        wait_valid(lat);
        wait_out(y);
        chk("t6_coef_kept", y, 700);
        wr_coef(0, 4000);
        out_ready = 0;
        accept(300);
        wait_valid(lat);
        #1;
        rst_n = 0;
        #1;
        chk("t6_async_hold_drop", out_valid, 0);
        tick();
        tick();
        rst_n = 1;
        out_ready = 1;
        accept(300);
        repeat (3) tick();
        #2;
        rst_n = 0;
        #1;
        chk("t6_async_mac_valid", out_valid, 0);
        tick();
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("t6_ready_after_rst", in_ready, 1);
        send(700, lat, y);
        chk("t6_coef_default", y, 700);

        // Random phase, model checks every cycle
        for (int c = 0; c < 3000; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = 16'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            coef_we    = ($urandom_range(0, 19) == 0);
            coef_addr  = 5'($urandom);
            coef_wdata = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                     : 16'($urandom_range(0, 8192) - 4096);
            if ($urandom_range(0, 99) == 0) train_en = ~train_en;
            tick();
        end
        in_valid  = 0;
        coef_we   = 0;
        train_en  = 0;
        out_ready = 1;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
